// File: rtl/nios2_oci_dct_capture.sv
// Debug-capture trace buffer: circular store of dct words with FWFT read port and end-of-test drain.
// Optional OCI_DCT_TIMESTAMP_EN prepends a 16-bit free-running cycle stamp to every entry.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_CAPTURE | accepting capture words
// ST_DRAIN   | end requested; pushes ignored, waiting for the buffer to empty
// ST_ENDED   | drain complete, test_has_ended held until reset
module nios2_oci_dct_capture #(
  parameter int DATA_W    = 30,
  parameter int COUNT_W   = 4,
  parameter int DEPTH     = 16,
  parameter int WRAP_MODE = 0,
`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int ENTRY_W  = COUNT_W + DATA_W + 16,
`else
  localparam int ENTRY_W  = COUNT_W + DATA_W,
`endif
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dct_valid,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               test_ending,
  input  logic               rd_ready,
  output logic               rd_valid,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [AW:0]        fill_level,
  output logic               overflow,
  output logic               test_has_ended
);

  typedef enum logic [1:0] {ST_CAPTURE, ST_DRAIN, ST_ENDED} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t             state, state_nxt;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [ENTRY_W-1:0] wr_entry;
  logic               push_req, pop, full;
  logic               do_write, force_adv, fill_inc, set_ovf;

`ifdef OCI_DCT_TIMESTAMP_EN
  logic [15:0] stamp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stamp <= '0;
    else          stamp <= stamp + 16'd1;
  end

  assign wr_entry = {stamp, dct_count, dct_buffer};
`else
  assign wr_entry = {dct_count, dct_buffer};
`endif

  assign rd_valid       = (fill_level != '0);
  assign rd_data        = mem[rd_ptr];
  assign test_has_ended = (state == ST_ENDED);

  // In wrap mode a full push without a pop evicts the oldest entry by dragging rd_ptr along.
  always_comb begin
    push_req  = dct_valid && (state == ST_CAPTURE);
    pop       = rd_valid && rd_ready;
    full      = (fill_level == FULL_LVL);
    do_write  = push_req && (!full || pop || (WRAP_MODE != 0));
    force_adv = push_req && full && !pop && (WRAP_MODE != 0);
    fill_inc  = do_write && !force_adv;
    set_ovf   = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_write)           wr_ptr <= wr_ptr + 1'b1;
      if (pop || force_adv)   rd_ptr <= rd_ptr + 1'b1;
      if (fill_inc && !pop)   fill_level <= fill_level + 1'b1;
      else if (!fill_inc && pop) fill_level <= fill_level - 1'b1;
      if (set_ovf)            overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CAPTURE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CAPTURE: if (test_ending)        state_nxt = ST_DRAIN;
      ST_DRAIN:   if (fill_level == '0)   state_nxt = ST_ENDED;
      ST_ENDED:                           state_nxt = ST_ENDED;
      default:                            state_nxt = ST_CAPTURE;
    endcase
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Bench for nios2_oci_dct_capture: stop-mode DUT (depth 16) and wrap-mode DUT (depth 4),
// directed steps with a queue scoreboard of expected entries.
module tb_nios2_oci_dct_capture;

`ifdef OCI_DCT_TIMESTAMP_EN
  localparam int EW = 4 + 30 + 16;
`else
  localparam int EW = 4 + 30;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;

  logic          v0 = 1'b0, te0 = 1'b0, rr0 = 1'b0;
  logic [29:0]   b0 = '0;
  logic [3:0]    c0 = '0;
  logic          rv0, ov0, th0;
  logic [EW-1:0] rd0;
  logic [4:0]    fl0;

  logic          v1 = 1'b0, te1 = 1'b0, rr1 = 1'b0;
  logic [29:0]   b1 = '0;
  logic [3:0]    c1 = '0;
  logic          rv1, ov1, th1;
  logic [EW-1:0] rd1;
  logic [2:0]    fl1;

  logic [33:0]   q0 [$];
  logic [33:0]   q1 [$];
  int            n_cmp = 0;
  int            n_mis = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(16), .WRAP_MODE(0)) u_stop (
    .clk(clk), .reset_n(reset_n), .dct_valid(v0), .dct_buffer(b0), .dct_count(c0),
    .test_ending(te0), .rd_ready(rr0), .rd_valid(rv0), .rd_data(rd0),
    .fill_level(fl0), .overflow(ov0), .test_has_ended(th0));

  nios2_oci_dct_capture #(.DATA_W(30), .COUNT_W(4), .DEPTH(4), .WRAP_MODE(1)) u_wrap (
    .clk(clk), .reset_n(reset_n), .dct_valid(v1), .dct_buffer(b1), .dct_count(c1),
    .test_ending(te1), .rd_ready(rr1), .rd_valid(rv1), .rd_data(rd1),
    .fill_level(fl1), .overflow(ov1), .test_has_ended(th1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    v0 = 0; te0 = 0; rr0 = 0; v1 = 0; te1 = 0; rr1 = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q0.delete();
    q1.delete();
  endtask

  // Starts and ends at a falling edge; the word is presented to exactly one rising edge.
  task automatic push(input int which, input logic [29:0] d, input logic [3:0] c, input bit keep);
    if (which == 0) begin
      v0 = 1'b1; b0 = d; c0 = c;
      if (keep) q0.push_back({c, d});
    end else begin
      v1 = 1'b1; b1 = d; c1 = c;
      if (keep) q1.push_back({c, d});
    end
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic drain(input int which, input int n_exp, input string tag);
    int          pops = 0;
    logic [33:0] e;
    if (which == 0) rr0 = 1'b1; else rr1 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (((which == 0) ? rv0 : rv1) !== 1'b1) break;
      if (which == 0) e = (q0.size() > 0) ? q0.pop_front() : 34'h3_dead_beef;
      else            e = (q1.size() > 0) ? q1.pop_front() : 34'h3_dead_beef;
      chk(tag, (which == 0) ? rd0[33:0] : rd1[33:0], e);
      pops++;
      @(negedge clk);
    end
    rr0 = 1'b0; rr1 = 1'b0;
    chk({tag, "_count"}, pops, n_exp);
  endtask

  initial begin
    do_reset();
    chk("rst_rd_valid", rv0, 0);
    chk("rst_fill", fl0, 0);
    chk("rst_overflow", ov0, 0);
    chk("rst_ended", th0, 0);

    // basic ordering with held ready low
    push(0, 30'h1, 4'h1, 1);
    chk("first_word_valid", rv0, 1);
    push(0, 30'h2, 4'h1, 1);
    push(0, 30'h3, 4'h1, 1);
    chk("basic_fill", fl0, 3);
    chk("fwft_head", rd0[33:0], q0[0]);
    @(negedge clk);
    chk("fwft_stable", rd0[33:0], q0[0]);
    drain(0, 3, "basic_rd");
    chk("basic_empty", rv0, 0);

    // stop mode: 17th word dropped
    for (int i = 0; i < 17; i++) push(0, 30'(i), 4'h0, i < 16);
    chk("stop_fill", fl0, 16);
    chk("stop_overflow", ov0, 1);
    drain(0, 16, "stop_rd");

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 16; i++) push(0, 30'(100 + i), 4'h2, 1);
    chk("sim_fill_pre", fl0, 16);
    chk("sim_head", rd0[33:0], q0.pop_front());
    q0.push_back({4'h2, 30'hAA});
    v0 = 1'b1; b0 = 30'hAA; c0 = 4'h2; rr0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0; rr0 = 1'b0;
    chk("sim_fill_post", fl0, 16);
    chk("sim_no_overflow", ov0, 0);
    drain(0, 16, "sim_rd");

    // wrap mode, depth 4: oldest two overwritten
    for (int i = 0; i < 6; i++) push(1, 30'(i), 4'h3, i >= 2);
    chk("wrap_overflow", ov1, 1);
    chk("wrap_fill", fl1, 4);
    drain(1, 4, "wrap_rd");

    // end of test with two entries stored
    do_reset();
    push(0, 30'h10, 4'h5, 1);
    push(0, 30'h11, 4'h5, 1);
    te0 = 1'b1;
    @(negedge clk);
    te0 = 1'b0;
    push(0, 30'h55, 4'h5, 0);
    chk("eot_fill", fl0, 2);
    chk("eot_overflow", ov0, 0);
    chk("eot_not_ended", th0, 0);
    drain(0, 2, "eot_rd");
    chk("eot_ended_lag", th0, 0);
    @(negedge clk);
    chk("eot_ended", th0, 1);
    te0 = 1'b1;
    push(0, 30'h66, 4'h5, 0);
    te0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("eot_ended_hold", th0, 1);
    chk("eot_ignored_push", fl0, 0);

    // end request while already empty: two cycles
    do_reset();
    te0 = 1'b1;
    @(negedge clk);
    te0 = 1'b0;
    chk("empty_end_1", th0, 0);
    @(negedge clk);
    chk("empty_end_2", th0, 1);

    // reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 17; i++) push(0, 30'(i), 4'h1, 0);
    te0 = 1'b1;
    @(negedge clk);
    te0 = 1'b0; rr0 = 1'b1;
    @(negedge clk);
    rr0 = 1'b0;
    chk("mid_fill_pre", fl0, 15);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", rv0, 0);
    chk("mid_rst_fill", fl0, 0);
    chk("mid_rst_overflow", ov0, 0);
    chk("mid_rst_ended", th0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push(0, 30'h77, 4'h7, 1);
    chk("post_rst_capture", fl0, 1);
    drain(0, 1, "post_rst_rd");

`ifdef OCI_DCT_TIMESTAMP_EN
    begin
      logic [15:0] st [3];
      do_reset();
      push(0, 30'hA, 4'h1, 1);
      repeat (3) @(negedge clk);
      push(0, 30'hB, 4'h1, 1);
      repeat (65535) @(negedge clk);
      push(0, 30'hC, 4'h1, 1);
      rr0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
        chk("ts_valid", rv0, 1);
        st[i] = rd0[EW-1 -: 16];
        chk("ts_word", rd0[33:0], q0.pop_front());
        @(negedge clk);
      end
      rr0 = 1'b0;
      chk("ts_first_zero", st[0], 16'd0);
      chk("ts_delta4", 16'(st[1] - st[0]), 16'd4);
      chk("ts_wrap", st[2], st[1]);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_capture.md
# nios2_oci_dct_capture

Parametrised debug-capture trace buffer for the Nios II on-chip instrumentation (OCI) path. Stores each valid capture word (`dct_buffer`, `dct_count`) into a circular buffer of configurable depth. Supports stop-when-full or overwrite-oldest modes and exposes a first-word-fall-through valid/ready read port. Sequences end-of-test: a drain phase, then a sticky `test_has_ended` flag.

## Interface

Parameters:
- `DATA_W`, 30, capture word width.
- `COUNT_W`, 4, capture count width.
- `DEPTH`, 16, buffer entries; power of two, 4..256.
- `WRAP_MODE`, 0, 0 = stop when full (drop new), 1 = overwrite oldest.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `reset_n`, in, 1, asynchronous active-low reset.
- `dct_valid`, in, 1, capture word present this cycle.
- `dct_buffer`, in, `DATA_W`, capture data.
- `dct_count`, in, `COUNT_W`, capture count.
- `test_ending`, in, 1, request end-of-test (level or pulse).
- `rd_ready`, in, 1, consumer accepts `rd_data`.
- `rd_valid`, out, 1, buffer non-empty.
- `rd_data`, out, `ENTRY_W`, oldest entry. Layout `{[stamp,] dct_count, dct_buffer}`.
- `fill_level`, out, log2(`DEPTH`)+1, occupied entries.
- `overflow`, out, 1, sticky: an entry was dropped or overwritten.
- `test_has_ended`, out, 1, sticky: drain complete.

`ENTRY_W` = `COUNT_W`+`DATA_W`, plus 16 when `OCI_DCT_TIMESTAMP_EN` is defined.

## Operation

- Storage: `DEPTH` x `ENTRY_W` array with `wr_ptr` and `rd_ptr` of log2(`DEPTH`) bits. Pointers wrap modulo `DEPTH`. `fill_level` is held in a separate counter.
- Push occurs when `dct_valid`=1 and state=CAPTURE. Pop occurs when `rd_valid`=1 and `rd_ready`=1.
- Full, push, no pop:
  - `WRAP_MODE`=0: the word is dropped, `overflow` is set, and the pointers are unchanged.
  - `WRAP_MODE`=1: the word is written at `wr_ptr`, both pointers advance, `fill_level` stays at `DEPTH`, and `overflow` is set.
- Full, push and pop together: both take effect, `fill_level` is unchanged, and `overflow` is not set (either mode).
- Empty, push: a pop in the same cycle is impossible because `rd_valid`=0.
- State machine:
  - CAPTURE → DRAIN when `test_ending`=1. A push in that same cycle is still accepted.
  - DRAIN: pushes are ignored without setting `overflow`; pops continue. DRAIN → ENDED when `fill_level`=0.
  - ENDED: `test_has_ended`=1. `test_ending` is ignored and pops are still allowed. Leaves ENDED only on reset.
  - If `test_ending` arrives while already empty: CAPTURE → DRAIN, then ENDED on the next cycle.
- Reset mid-operation: all contents are discarded, pointers go to 0, state goes to CAPTURE. Array contents are don't-care.

## Timing

- Reset values: `rd_valid`=0, `fill_level`=0, `overflow`=0, `test_has_ended`=0. `rd_data` is don't-care while `rd_valid`=0.
- Push to `rd_valid`: 1 cycle. A word pushed at edge N is visible with `rd_valid`=1 after edge N.
- Read is first-word-fall-through: `rd_data` is stable while `rd_valid`=1 and `rd_ready`=0. The next entry is presented in the cycle after a pop.
- `fill_level` and `overflow` are updated registered, 1 cycle after the causing edge.
- `test_ending` to `test_has_ended`:
  - 2 cycles minimum when the buffer is empty.
  - Otherwise, 1 cycle after the pop that empties the buffer.
- Throughput: one push and one pop per cycle.

## Configuration

- `OCI_DCT_TIMESTAMP_EN` defined:
  - A 16-bit free-running cycle counter runs from reset. It resets to 0, increments every cycle, and wraps 0xFFFF→0x0000.
  - Its value at the push edge is stored in `rd_data[ENTRY_W-1 -: 16]`.
- Not defined: no counter, and `ENTRY_W` = `COUNT_W`+`DATA_W`.

## Test plan

- Basic FIFO (default parameters): push 3 words 0x1/0x2/0x3 (count 1) with `rd_ready`=0. Expect `fill_level`=3. Then `rd_ready`=1: expect data returned in order, one per cycle, then `rd_valid`=0.
- Stop mode overflow (`WRAP_MODE`=0): push 17 words 0..16. Expect `fill_level`=16 and `overflow`=1. Readout is 0..15; word 16 is lost.
- Wrap mode (`WRAP_MODE`=1, `DEPTH`=4): push 6 words 0..5. Expect `overflow`=1 and `fill_level`=4. Readout is 2,3,4,5.
- Full, simultaneous push and pop: at `fill_level`=16, push 0xAA with `rd_ready`=1. Expect `fill_level` stays 16 and `overflow`=0. 0xAA is read last.
- End of test: with 2 entries stored, pulse `test_ending` and push 0x55 in the following cycle. Expect 0x55 is not stored. `test_has_ended` rises 1 cycle after the second pop and holds. Assert `reset_n`=0 mid-drain in a second run: all outputs return to reset values.
- Timestamp (macro defined): push at cycles 5 and 9 after reset. Expect the stamps differ by 4. Run 65536+ cycles and confirm the counter wraps to 0.
